// File: rtl/cpudefs.sv
// Shared CPU definitions: RV32I memory access modes (funct3) and LSU FSM states.
package cpudefs;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } lsu_state_t;

    localparam int XLEN = 32;

endpackage

// File: rtl/lsu_lane_formatter.sv
// Combinational lane logic for the LSU: mode/alignment checks, byte enables,
// store-data replication and load extraction with sign/zero extension.
module lsu_lane_formatter
    import cpudefs::*;
(
    input  logic            write,
    input  logic [1:0]      lane,
    input  logic [2:0]      mode,
    input  logic [XLEN-1:0] write_data,
    input  logic [XLEN-1:0] mem_word,
    output logic [3:0]      byte_enable,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            bad_mode,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        bad_mode    = 1'b0;
        misaligned  = 1'b0;
        byte_enable = 4'b0000;
        store_data  = write_data;
        load_data   = '0;
        shifted     = mem_word >> {lane, 3'b000};

        if (write) begin
            bad_mode = mode[2] | (mode == 3'b011);
        end else begin
            case (mode)
                MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: bad_mode = 1'b0;
                default:                             bad_mode = 1'b1;
            endcase
        end

        // A bad mode hides any alignment fault so only one flag is ever raised.
        if (!bad_mode) begin
            misaligned = ((mode[1:0] == 2'b01) && lane[0]) ||
                         ((mode[1:0] == 2'b10) && (lane != 2'b00));
        end

        case (mode[1:0])
            2'b00:   store_data = {4{write_data[7:0]}};
            2'b01:   store_data = {2{write_data[15:0]}};
            default: store_data = write_data;
        endcase

        if (write) begin
            case (mode[1:0])
                2'b00:   byte_enable = 4'b0001 << lane;
                2'b01:   byte_enable = 4'b0011 << lane;
                default: byte_enable = 4'b1111;
            endcase
        end

        case (mode)
            MEM_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_BU:  load_data = {24'd0, shifted[7:0]};
            MEM_HU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request per handshake, issues a single word-aligned
// memory strobe, and returns extended load data or an error flag on a response handshake.
module load_store_unit
    import cpudefs::*;
#(
    parameter int MEM_LATENCY = 0
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_ReqValid,
    output logic        o_ReqReady,
    input  logic        i_ReqWrite,
    input  logic [31:0] i_ReqAddress,
    input  logic [31:0] i_ReqWriteData,
    input  logic [2:0]  i_ReqMode,
    output logic        o_RespValid,
    input  logic        i_RespReady,
    output logic [31:0] o_RespData,
    output logic        o_RespMisaligned,
    output logic        o_RespBadMode,
    output logic        o_MemReadEnable,
    output logic        o_MemWriteEnable,
    output logic [31:0] o_MemAddress,
    output logic [3:0]  o_MemByteEnable,
    output logic [31:0] o_MemDataOut,
    input  logic [31:0] i_MemDataIn
);

    // Handshakes: a request transfers on a rising edge where i_ReqValid and
    // o_ReqReady are both high; a response transfers where o_RespValid and
    // i_RespReady are both high. o_RespValid and its payload hold until then.

    localparam logic [1:0] WAIT_INIT = (MEM_LATENCY > 0) ? 2'(MEM_LATENCY - 1) : 2'd0;

    lsu_state_t  state, next_state;
    logic        ready_q, resp_valid_q;
    logic        req_write;
    logic [1:0]  req_lane;
    logic [2:0]  req_mode;
    logic [1:0]  wait_cnt;
    logic [31:0] resp_data;
    logic        resp_mis, resp_bad;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_dout;
    logic [3:0]  mem_be;

    logic        fmt_write;
    logic [1:0]  fmt_lane;
    logic [2:0]  fmt_mode;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_store, fmt_load;
    logic        fmt_bad, fmt_mis, fmt_err;
    logic        accept, issue, capture;

    // In IDLE the formatter checks the incoming request; afterwards it
    // works on the registered request to extract the returned word.
    assign fmt_write = (state == IDLE) ? i_ReqWrite        : req_write;
    assign fmt_lane  = (state == IDLE) ? i_ReqAddress[1:0] : req_lane;
    assign fmt_mode  = (state == IDLE) ? i_ReqMode         : req_mode;

    lsu_lane_formatter u_formatter (
        .write       (fmt_write),
        .lane        (fmt_lane),
        .mode        (fmt_mode),
        .write_data  (i_ReqWriteData),
        .mem_word    (i_MemDataIn),
        .byte_enable (fmt_be),
        .store_data  (fmt_store),
        .load_data   (fmt_load),
        .bad_mode    (fmt_bad),
        .misaligned  (fmt_mis)
    );

    assign fmt_err = fmt_bad | fmt_mis;
    assign accept  = i_ReqValid & ready_q & (state == IDLE);
    assign issue   = accept & ~fmt_err;
    assign capture = ~req_write &
                     (((state == ACCESS) && (MEM_LATENCY == 0)) ||
                      ((state == WAIT) && (wait_cnt == 2'd0)));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = fmt_err ? RESP : ACCESS;
            ACCESS:  next_state = (MEM_LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (wait_cnt == 2'd0) next_state = RESP;
            RESP:    if (i_RespReady) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            req_write    <= 1'b0;
            req_lane     <= 2'd0;
            req_mode     <= 3'd0;
            wait_cnt     <= 2'd0;
            resp_data    <= '0;
            resp_mis     <= 1'b0;
            resp_bad     <= 1'b0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_dout     <= '0;
        end else begin
            state        <= next_state;
            ready_q      <= (next_state == IDLE);
            resp_valid_q <= (next_state == RESP);

            if (accept) begin
                req_write <= i_ReqWrite;
                req_lane  <= i_ReqAddress[1:0];
                req_mode  <= i_ReqMode;
            end

            mem_re   <= issue & ~i_ReqWrite;
            mem_we   <= issue & i_ReqWrite;
            mem_be   <= issue ? fmt_be : 4'b0000;
            mem_dout <= issue ? fmt_store : 32'd0;
            // Address stays up while a slow memory is still answering.
            if (issue) begin
                mem_addr <= {i_ReqAddress[31:2], 2'b00};
            end else if (next_state != WAIT) begin
                mem_addr <= '0;
            end

            if (state == ACCESS) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end

            if (accept && fmt_err) begin
                resp_mis <= fmt_mis;
                resp_bad <= fmt_bad;
            end
            if (capture) begin
                resp_data <= fmt_load;
            end
            if ((state == RESP) && i_RespReady) begin
                resp_data <= '0;
                resp_mis  <= 1'b0;
                resp_bad  <= 1'b0;
            end
        end
    end

    assign o_ReqReady       = ready_q;
    assign o_RespValid      = resp_valid_q;
    assign o_RespData       = resp_data;
    assign o_RespMisaligned = resp_mis;
    assign o_RespBadMode    = resp_bad;
    assign o_MemReadEnable  = mem_re;
    assign o_MemWriteEnable = mem_we;
    assign o_MemAddress     = mem_addr;
    assign o_MemByteEnable  = mem_be;
    assign o_MemDataOut     = mem_dout;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a zero-latency and a two-cycle-latency
// instance share one byte-enable-honouring memory model.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_mode;
    logic        resp_ready;
    logic        valid0, valid2;

    logic        ready0, rv0, mis0, bad0, re0, we0;
    logic [31:0] rd0, maddr0, mdo0, mdi0;
    logic [3:0]  be0;
    logic        ready2, rv2, mis2, bad2, re2, we2;
    logic [31:0] rd2, maddr2, mdo2, mdi2;
    logic [3:0]  be2;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.MEM_LATENCY(0)) dut0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_ReqValid(valid0), .o_ReqReady(ready0),
        .i_ReqWrite(req_write), .i_ReqAddress(req_addr), .i_ReqWriteData(req_wdata),
        .i_ReqMode(req_mode), .o_RespValid(rv0), .i_RespReady(resp_ready),
        .o_RespData(rd0), .o_RespMisaligned(mis0), .o_RespBadMode(bad0),
        .o_MemReadEnable(re0), .o_MemWriteEnable(we0), .o_MemAddress(maddr0),
        .o_MemByteEnable(be0), .o_MemDataOut(mdo0), .i_MemDataIn(mdi0)
    );

    load_store_unit #(.MEM_LATENCY(2)) dut2 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_ReqValid(valid2), .o_ReqReady(ready2),
        .i_ReqWrite(req_write), .i_ReqAddress(req_addr), .i_ReqWriteData(req_wdata),
        .i_ReqMode(req_mode), .o_RespValid(rv2), .i_RespReady(resp_ready),
        .o_RespData(rd2), .o_RespMisaligned(mis2), .o_RespBadMode(bad2),
        .o_MemReadEnable(re2), .o_MemWriteEnable(we2), .o_MemAddress(maddr2),
        .o_MemByteEnable(be2), .o_MemDataOut(mdo2), .i_MemDataIn(mdi2)
    );

    // Memory model: data valid only in the exact cycle the latency implies.
    logic [31:0] mem [0:255];
    logic        re2_d1 = 1'b0, re2_d2 = 1'b0;
    logic [7:0]  a2_d1 = 8'd0, a2_d2 = 8'd0;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we0 && be0[b]) mem[maddr0[9:2]][8*b +: 8] <= mdo0[8*b +: 8];
            if (we2 && be2[b]) mem[maddr2[9:2]][8*b +: 8] <= mdo2[8*b +: 8];
        end
        re2_d1 <= re2;
        re2_d2 <= re2_d1;
        a2_d1  <= maddr2[9:2];
        a2_d2  <= a2_d1;
    end

    assign mdi0 = re0    ? mem[maddr0[9:2]] : 32'hDEAD_BEEF;
    assign mdi2 = re2_d2 ? mem[a2_d2]       : 32'hDEAD_BEEF;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  mode;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_bad;
        logic [3:0]  exp_be;
        logic [31:0] exp_mdo;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] mode, input logic [31:0] exp_data,
                                input logic exp_mis, input logic exp_bad, input logic [3:0] exp_be,
                                input logic [31:0] exp_mdo, input logic [31:0] exp_maddr);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.mode = mode;
        v.exp_data = exp_data; v.exp_mis = exp_mis; v.exp_bad = exp_bad;
        v.exp_be = exp_be; v.exp_mdo = exp_mdo; v.exp_maddr = exp_maddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one request and follows it until the response appears.
    task automatic issue(input bit use2, input vec_t v, input int exp_lat);
        int   k;
        int   strobes;
        bit   got;
        logic c_we;
        logic [3:0]  c_be;
        logic [31:0] c_mdo, c_maddr;
        bit   err;
        err = v.exp_mis | v.exp_bad;
        @(negedge clk);
        req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_mode = v.mode;
        if (use2) valid2 = 1'b1; else valid0 = 1'b1;
        check("req_ready_before", use2 ? ready2 : ready0, 32'd1);
        k = 0; strobes = 0; got = 1'b0;
        c_we = 1'b0; c_be = '0; c_mdo = '0; c_maddr = '0;
        while (!got && k < 12) begin
            @(negedge clk);
            valid0 = 1'b0; valid2 = 1'b0;
            k++;
            if (use2 ? (re2 | we2) : (re0 | we0)) begin
                strobes++;
                c_we    = use2 ? we2 : we0;
                c_be    = use2 ? be2 : be0;
                c_mdo   = use2 ? mdo2 : mdo0;
                c_maddr = use2 ? maddr2 : maddr0;
            end
            if (use2 ? rv2 : rv0) got = 1'b1;
        end
        check("resp_latency", k, exp_lat);
        check("strobe_count", strobes, err ? 0 : 1);
        if (!err) begin
            check("strobe_kind", c_we, v.wr);
            check("byte_enable", c_be, v.exp_be);
            check("mem_data_out", c_mdo, v.exp_mdo);
            check("mem_address", c_maddr, v.exp_maddr);
        end
        check("resp_data", use2 ? rd2 : rd0, v.exp_data);
        check("resp_misaligned", use2 ? mis2 : mis0, v.exp_mis);
        check("resp_bad_mode", use2 ? bad2 : bad0, v.exp_bad);
    endtask

    task automatic finish_resp(input bit use2);
        @(negedge clk);
        check("ready_after_resp", use2 ? ready2 : ready0, 32'd1);
        check("valid_after_resp", use2 ? rv2 : rv0, 32'd0);
    endtask

    task automatic do_req(input bit use2, input vec_t v, input int exp_lat);
        issue(use2, v, exp_lat);
        finish_resp(use2);
    endtask

    task automatic check_all_zero(input string tag, input bit use2);
        check({tag, "_ready"},    use2 ? ready2 : ready0, 32'd0);
        check({tag, "_rvalid"},   use2 ? rv2 : rv0, 32'd0);
        check({tag, "_rdata"},    use2 ? rd2 : rd0, 32'd0);
        check({tag, "_flags"},    use2 ? {mis2, bad2} : {mis0, bad0}, 32'd0);
        check({tag, "_strobes"},  use2 ? {re2, we2} : {re0, we0}, 32'd0);
        check({tag, "_maddr"},    use2 ? maddr2 : maddr0, 32'd0);
        check({tag, "_be"},       use2 ? be2 : be0, 32'd0);
        check({tag, "_mdo"},      use2 ? mdo2 : mdo0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h80] = 32'h80FF_7F01;
        mem[8'h81] = 32'h1122_3344;

        //               wr  addr     wdata         mode    data          mis  bad  be       mdo           maddr
        vecs[0]  = mk(1, 32'h103, 32'h0000_00AB, 3'b000, 32'h0,         0, 0, 4'b1000, 32'hABAB_ABAB, 32'h100);
        vecs[1]  = mk(0, 32'h201, 32'h0,         3'b000, 32'h0000_007F, 0, 0, 4'b0000, 32'h0,         32'h200);
        vecs[2]  = mk(0, 32'h203, 32'h0,         3'b000, 32'hFFFF_FF80, 0, 0, 4'b0000, 32'h0,         32'h200);
        vecs[3]  = mk(0, 32'h202, 32'h0,         3'b101, 32'h0000_80FF, 0, 0, 4'b0000, 32'h0,         32'h200);
        vecs[4]  = mk(0, 32'h202, 32'h0,         3'b001, 32'hFFFF_80FF, 0, 0, 4'b0000, 32'h0,         32'h200);
        vecs[5]  = mk(0, 32'h200, 32'h0,         3'b010, 32'h80FF_7F01, 0, 0, 4'b0000, 32'h0,         32'h200);
        vecs[6]  = mk(0, 32'h203, 32'h0,         3'b100, 32'h0000_0080, 0, 0, 4'b0000, 32'h0,         32'h200);
        vecs[7]  = mk(0, 32'h200, 32'h0,         3'b001, 32'h0000_7F01, 0, 0, 4'b0000, 32'h0,         32'h200);
        vecs[8]  = mk(0, 32'h206, 32'h0,         3'b010, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0);
        vecs[9]  = mk(1, 32'h205, 32'hFFFF_FFFF, 3'b001, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0);
        vecs[10] = mk(0, 32'h201, 32'h0,         3'b011, 32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
        vecs[11] = mk(1, 32'h200, 32'h1234_5678, 3'b110, 32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
        vecs[12] = mk(1, 32'h201, 32'h1234_5678, 3'b011, 32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
        vecs[13] = mk(0, 32'h201, 32'h0,         3'b101, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0);
        vecs[14] = mk(1, 32'h102, 32'h1234_5678, 3'b001, 32'h0,         0, 0, 4'b1100, 32'h5678_5678, 32'h100);
        vecs[15] = mk(1, 32'h104, 32'hCAFE_F00D, 3'b010, 32'h0,         0, 0, 4'b1111, 32'hCAFE_F00D, 32'h104);
        vecs[16] = mk(0, 32'h100, 32'h0,         3'b010, 32'h5678_0000, 0, 0, 4'b0000, 32'h0,         32'h100);
        vecs[17] = mk(0, 32'h104, 32'h0,         3'b010, 32'hCAFE_F00D, 0, 0, 4'b0000, 32'h0,         32'h104);
        vecs[18] = mk(0, 32'h204, 32'h0,         3'b010, 32'h1122_3344, 0, 0, 4'b0000, 32'h0,         32'h204);

        rst_n = 1'b0; valid0 = 1'b0; valid2 = 1'b0; resp_ready = 1'b1;
        req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mode = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("rst0", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready0_after_reset", ready0, 32'd1);
        check("ready2_after_reset", ready2, 32'd1);

        // Table vectors on the zero-latency unit
        for (int i = 0; i < 19; i++) begin
            do_req(1'b0, vecs[i], (vecs[i].exp_mis | vecs[i].exp_bad) ? 1 : 2);
        end

        // Consumer stalls: response held, new request ignored until after the bubble
        resp_ready = 1'b0;
        issue(1'b0, vecs[5], 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid0 = 1'b1; req_write = 1'b0; req_addr = 32'h201; req_mode = 3'b000;
            check("stall_rvalid", rv0, 32'd1);
            check("stall_rdata", rd0, 32'h80FF_7F01);
            check("stall_ready", ready0, 32'd0);
            check("stall_no_strobe", {re0, we0}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        check("bubble_rvalid", rv0, 32'd0);
        check("bubble_ready", ready0, 32'd1);
        check("bubble_no_strobe", {re0, we0}, 32'd0);
        do_req(1'b0, vecs[1], 2);

        // Two-cycle memory latency
        do_req(1'b1, vecs[5], 4);
        do_req(1'b1, vecs[2], 4);
        do_req(1'b1, vecs[8], 1);

        // Reset while waiting on memory
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h200; req_mode = 3'b010; valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        check("abort_strobe_seen", re2, 32'd1);
        @(negedge clk);
        check("abort_in_wait_addr", maddr2, 32'h200);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort", 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", ready2, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_stale_resp", rv2, 32'd0);
            check("abort_no_strobe", {re2, we2}, 32'd0);
        end
        do_req(1'b1, vecs[18], 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
